// File: rtl/ddp_pkt_rx_fifo.sv
// Receive stage behind the CE pipeline: accepts active-low 4-phase Send/Ack bundled-data packets,
// resynchronises Send_in into the cp domain and buffers packets in a show-ahead valid/ready FIFO.
module ddp_pkt_rx_fifo #(
  parameter int DW          = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          cp,
  input  logic          MR_n,
  input  logic          Send_in,
  input  logic [DW-1:0] Data_in,
  output logic          Ack_out,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  typedef enum logic {
    IDLE = 1'b0,
    ACKD = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s_send;
  logic                   ack_nxt;
  logic                   push;
  logic                   pop;
  logic [DW-1:0]          mem [DEPTH];
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic [AW-1:0]          wptr_nxt;
  logic [AW-1:0]          rptr_nxt;
  logic [CW-1:0]          count_nxt;
  logic [DW-1:0]          head_nxt;

  assign s_send = sync[SYNC_STAGES-1];

  // Send_in synchroniser; idle level is 1 so reset never looks like a request
  always_ff @(posedge cp or negedge MR_n) begin
    if (!MR_n) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], Send_in};
    end
  end

  // Handshake FSM: one push per Send_in low phase, stalls while the FIFO is full
  always_comb begin
    state_nxt = state;
    ack_nxt   = Ack_out;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (!s_send && !full) begin
          state_nxt = ACKD;
          ack_nxt   = 1'b0;
          push      = 1'b1;
        end else begin
          state_nxt = IDLE;
          ack_nxt   = 1'b1;
        end
      end
      ACKD: begin
        if (s_send) begin
          state_nxt = IDLE;
          ack_nxt   = 1'b1;
        end else begin
          state_nxt = ACKD;
          ack_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        ack_nxt   = 1'b1;
      end
    endcase
  end

  // FSM state and registered acknowledge
  always_ff @(posedge cp or negedge MR_n) begin
    if (!MR_n) begin
      state   <= IDLE;
      Ack_out <= 1'b1;
    end else begin
      state   <= state_nxt;
      Ack_out <= ack_nxt;
    end
  end

  // Next FIFO bookkeeping; the head register mirrors mem[rptr] as it will be after this edge
  always_comb begin
    pop       = out_valid & out_ready;
    wptr_nxt  = wptr;
    rptr_nxt  = rptr;
    count_nxt = count;
    if (push) begin
      wptr_nxt = wptr + 1'b1;
    end else begin
      wptr_nxt = wptr;
    end
    if (pop) begin
      rptr_nxt = rptr + 1'b1;
    end else begin
      rptr_nxt = rptr;
    end
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
    if (push && (wptr == rptr_nxt)) begin
      head_nxt = Data_in;
    end else begin
      head_nxt = mem[rptr_nxt];
    end
  end

  // Packet storage, cleared on reset so the head is never X
  always_ff @(posedge cp or negedge MR_n) begin
    if (!MR_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wptr] <= Data_in;
    end else begin
      mem[wptr] <= mem[wptr];
    end
  end

  // Pointers, occupancy flags and show-ahead head
  always_ff @(posedge cp or negedge MR_n) begin
    if (!MR_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      wptr      <= wptr_nxt;
      rptr      <= rptr_nxt;
      count     <= count_nxt;
      full      <= (count_nxt == CW'(DEPTH));
      empty     <= (count_nxt == '0);
      out_valid <= (count_nxt != '0);
      out_data  <= head_nxt;
    end
  end

endmodule

// File: tb/tb_ddp_pkt_rx_fifo.sv
// Self-checking bench for ddp_pkt_rx_fifo: an upstream handshake driver, a queue-based packet model
// and a consumer-side scoreboard that checks order, occupancy and flags every cycle.
module tb_ddp_pkt_rx_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          cp = 1'b0;
  logic          MR_n;
  logic          Send_in;
  logic [DW-1:0] Data_in;
  logic          Ack_out;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  int            errors = 0;
  int            checks = 0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_d;

  always #5 cp = ~cp;

  ddp_pkt_rx_fifo #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .cp(cp), .MR_n(MR_n), .Send_in(Send_in), .Data_in(Data_in), .Ack_out(Ack_out),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty)
  );

  task automatic tick();
    @(posedge cp);
    #2;
  endtask

  // Consumer scoreboard: inputs settle 2 units after posedge, so the negedge sees what the next edge will use
  always @(negedge cp) begin
    if (mon_en) begin
      checks++;
      if (count !== CW'(exp_q.size()) || out_valid !== (exp_q.size() != 0) ||
          full !== (exp_q.size() == DEPTH) || empty !== (exp_q.size() == 0)) begin
        errors++;
        $display("FAIL status @%0t: count=%0d valid=%b full=%b empty=%b, expected count=%0d",
                 $time, count, out_valid, full, empty, exp_q.size());
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_empty @%0t: out_data=%h popped with no packet expected", $time, out_data);
        end else begin
          mon_d = exp_q.pop_front();
          if (out_data !== mon_d) begin
            errors++;
            $display("FAIL out_data @%0t: got %h, expected %h", $time, out_data, mon_d);
          end
        end
      end
    end
  end

  task automatic wait_ack(input logic lvl, input int limit, output int n);
    n = 0;
    while (Ack_out !== lvl && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (Ack_out !== lvl) begin
      errors++;
      $display("FAIL ack_timeout: Ack_out=%b after %0d cycles, expected %b", Ack_out, n, lvl);
    end
  endtask

  task automatic handshake(input logic [DW-1:0] d, input int hold);
    int n;
    Data_in = d;
    Send_in = 1'b0;
    wait_ack(1'b0, 100, n);
    if (Ack_out === 1'b0) exp_q.push_back(d);
    repeat (hold) tick();
    Send_in = 1'b1;
    wait_ack(1'b1, 100, n);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL drain: %0d packets still expected, empty=%b", exp_q.size(), empty);
    end
  endtask

  task automatic test_reset();
    MR_n      = 1'b0;
    Send_in   = 1'b1;
    out_ready = 1'b0;
    Data_in   = '0;
    #12;
    checks++;
    if (Ack_out !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_out: Ack_out=%b out_valid=%b out_data=%h, expected 1 0 0", Ack_out, out_valid, out_data);
    end
    checks++;
    if (count !== '0 || full !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: count=%0d full=%b empty=%b, expected 0 0 1", count, full, empty);
    end
    tick();
    MR_n = 1'b1;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    int n;
    Data_in = 32'hA5A5_0001;
    Send_in = 1'b0;
    wait_ack(1'b0, 20, n);
    checks++;
    if (n != SYNC + 1) begin
      errors++;
      $display("FAIL ack_fall_latency: %0d cycles, expected %0d", n, SYNC + 1);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL single_head: out_valid=%b out_data=%h, expected 1 a5a50001", out_valid, out_data);
    end
    if (Ack_out === 1'b0) exp_q.push_back(32'hA5A5_0001);
    repeat (2) tick();
    Send_in = 1'b1;
    wait_ack(1'b1, 20, n);
    checks++;
    if (n != SYNC + 1) begin
      errors++;
      $display("FAIL ack_rise_latency: %0d cycles, expected %0d", n, SYNC + 1);
    end
    drain();
  endtask

  task automatic test_fill_stall();
    int n;
    bit stalled_ok = 1'b1;
    out_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) handshake(DW'(i), 0);
    checks++;
    if (full !== 1'b1 || count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL fill: full=%b count=%0d, expected 1 %0d", full, count, DEPTH);
    end
    Data_in = DW'(DEPTH + 1);
    Send_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Ack_out !== 1'b1) stalled_ok = 1'b0;
    end
    checks++;
    if (!stalled_ok) begin
      errors++;
      $display("FAIL stall_ack: Ack_out went 0 while full, expected 1 throughout");
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (full !== 1'b0 || Ack_out !== 1'b1) begin
      errors++;
      $display("FAIL stall_pop_edge: full=%b Ack_out=%b, expected 0 1", full, Ack_out);
    end
    tick();
    checks++;
    if (Ack_out !== 1'b0 || count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL stall_admit: Ack_out=%b count=%0d, expected 0 %0d", Ack_out, count, DEPTH);
    end
    if (Ack_out === 1'b0) exp_q.push_back(DW'(DEPTH + 1));
    Send_in = 1'b1;
    wait_ack(1'b1, 20, n);
    drain();
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      handshake(DW'(i), int'($urandom_range(0, 3)));
      checks++;
      if (count > CW'(1)) begin
        errors++;
        $display("FAIL wrap_count: count=%0d after packet %0d, expected <=1", count, i);
      end
    end
    drain();
  endtask

  task automatic test_push_pop();
    int n;
    logic [DW-1:0] d;
    out_ready = 1'b0;
    handshake($urandom, 0);
    handshake($urandom, 0);
    d = $urandom;
    Data_in = d;
    Send_in = 1'b0;
    repeat (SYNC) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (Ack_out !== 1'b0 || count !== CW'(2)) begin
      errors++;
      $display("FAIL push_pop: Ack_out=%b count=%0d, expected 0 2", Ack_out, count);
    end
    if (Ack_out === 1'b0) exp_q.push_back(d);
    Send_in = 1'b1;
    wait_ack(1'b1, 20, n);
    drain();
  endtask

  task automatic test_long_low();
    int c0;
    out_ready = 1'b0;
    handshake($urandom, 0);
    c0 = exp_q.size();
    handshake($urandom, 50);
    repeat (3) tick();
    checks++;
    if (count !== CW'(c0 + 1)) begin
      errors++;
      $display("FAIL long_low: count=%0d, expected %0d", count, c0 + 1);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int n;
    out_ready = 1'b0;
    handshake($urandom, 0);
    handshake($urandom, 0);
    Data_in = $urandom;
    Send_in = 1'b0;
    wait_ack(1'b0, 20, n);
    if (Ack_out === 1'b0) exp_q.push_back(Data_in);
    checks++;
    if (count !== CW'(3)) begin
      errors++;
      $display("FAIL pre_reset_count: count=%0d, expected 3", count);
    end
    mon_en = 1'b0;
    #1;
    MR_n    = 1'b0;
    Send_in = 1'b1;
    #1;
    checks++;
    if (Ack_out !== 1'b1 || count !== '0 || empty !== 1'b1 || out_valid !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: Ack_out=%b count=%0d empty=%b out_valid=%b full=%b, expected 1 0 1 0 0",
               Ack_out, count, empty, out_valid, full);
    end
    exp_q.delete();
    tick();
    tick();
    MR_n   = 1'b1;
    mon_en = 1'b1;
    handshake($urandom, 1);
    checks++;
    if (count !== CW'(1) || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_rx: count=%0d out_valid=%b, expected 1 1", count, out_valid);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_wrap();
    test_push_pop();
    test_long_low();
    test_reset_mid();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
